// File: rtl/timeset_controller.sv
// Time-set controller.
// Turns debounced hour/minute set-button levels into single-cycle increment
// strobes. A fresh press gives one immediate strobe. While the button stays
// held, each timeset-divider strobe gives a further increment. After
// FAST_AFTER_S one-second ticks the divider is switched to its fast rate.
module timeset_controller #(
  parameter int FAST_AFTER_S = 3,
  parameter int HOLD_W       = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_set_hours,
  input  logic i_set_minutes,
  input  logic i_1hz_stb,
  input  logic i_timeset_stb,
  output logic o_div_en,
  output logic o_fast_set,
  output logic o_hours_inc_stb,
  output logic o_minutes_inc_stb,
  output logic o_setting
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SLOW = 2'd1;
  localparam logic [1:0] ST_FAST = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(FAST_AFTER_S);

  logic [1:0]        state_reg, state_next;
  logic              sel_reg, sel_next;          // 1 = hours, 0 = minutes
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [HOLD_W-1:0] hold_inc;
  logic              sel_held;
  logic              inc_next;
  logic              hours_inc_next, minutes_inc_next;
  logic              active_next, fast_next;

  // Next-state, selection latch, hold counter and increment decision
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    hold_cnt_next = hold_cnt_reg;
    inc_next      = 1'b0;
    hold_inc      = hold_cnt_reg + HOLD_W'(1);
    sel_held      = sel_reg ? i_set_hours : i_set_minutes;

    case (state_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        // Hours wins when both buttons are pressed together
        if (i_set_hours) begin
          state_next = ST_SLOW;
          sel_next   = 1'b1;
          inc_next   = 1'b1;
        end else if (i_set_minutes) begin
          state_next = ST_SLOW;
          sel_next   = 1'b0;
          inc_next   = 1'b1;
        end
      end
      ST_SLOW, ST_FAST: begin
        if (!sel_held) begin
          // Release beats any coincident divider strobe
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else begin
          inc_next = i_timeset_stb;
          // Counter saturates at the target so it can never wrap
          if (i_1hz_stb && (hold_cnt_reg != HOLD_TARGET)) begin
            hold_cnt_next = hold_inc;
            if ((state_reg == ST_SLOW) && (hold_inc == HOLD_TARGET)) begin
              state_next = ST_FAST;
            end
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase

    hours_inc_next   = inc_next & sel_next;
    minutes_inc_next = inc_next & ~sel_next;
    active_next      = (state_next != ST_IDLE);
    fast_next        = (state_next == ST_FAST);
  end

  // Control state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      sel_reg      <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Registered outputs, derived from the upcoming state so they change with it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_div_en          <= 1'b0;
      o_fast_set        <= 1'b0;
      o_setting         <= 1'b0;
      o_hours_inc_stb   <= 1'b0;
      o_minutes_inc_stb <= 1'b0;
    end else begin
      o_div_en          <= active_next;
      o_fast_set        <= fast_next;
      o_setting         <= active_next;
      o_hours_inc_stb   <= hours_inc_next;
      o_minutes_inc_stb <= minutes_inc_next;
    end
  end

endmodule

// File: tb/tb_timeset_controller.sv
// Directed testbench for timeset_controller (FAST_AFTER_S=3, HOLD_W=3).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the result of the edge just taken.
module tb_timeset_controller;

  logic i_clk;
  logic i_reset;
  logic i_set_hours;
  logic i_set_minutes;
  logic i_1hz_stb;
  logic i_timeset_stb;
  logic o_div_en;
  logic o_fast_set;
  logic o_hours_inc_stb;
  logic o_minutes_inc_stb;
  logic o_setting;

  int tests_run;
  int tests_failed;

  timeset_controller #(
    .FAST_AFTER_S(3),
    .HOLD_W      (3)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_set_hours      (i_set_hours),
    .i_set_minutes    (i_set_minutes),
    .i_1hz_stb        (i_1hz_stb),
    .i_timeset_stb    (i_timeset_stb),
    .o_div_en         (o_div_en),
    .o_fast_set       (o_fast_set),
    .o_hours_inc_stb  (o_hours_inc_stb),
    .o_minutes_inc_stb(o_minutes_inc_stb),
    .o_setting        (o_setting)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset       = 1'b1;
    i_set_hours   = 1'b0;
    i_set_minutes = 1'b0;
    i_1hz_stb     = 1'b0;
    i_timeset_stb = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    do_reset();
    outs = {o_div_en, o_fast_set, o_hours_inc_stb, o_minutes_inc_stb, o_setting};
    tests_run++;
    if (outs !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got=%b exp=00000", outs);
    end
    // Divider strobes in IDLE must do nothing
    i_timeset_stb = 1'b1;
    i_1hz_stb     = 1'b1;
    tick();
    i_timeset_stb = 1'b0;
    i_1hz_stb     = 1'b0;
    outs = {o_div_en, o_fast_set, o_hours_inc_stb, o_minutes_inc_stb, o_setting};
    tests_run++;
    if (outs !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ignores_strobes got=%b exp=00000", outs);
    end
    $display("[TB] reset: outputs=%b", outs);
  endtask

  task automatic test_tap();
    int hours_cnt = 0;
    int div_cnt   = 0;
    int fast_cnt  = 0;
    int min_cnt   = 0;
    i_set_hours = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) i_set_hours = 1'b0;
      if (c == 1) begin
        tests_run++;
        if (o_hours_inc_stb !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL tap_first_strobe got=%b exp=1", o_hours_inc_stb);
        end
      end
      if (o_hours_inc_stb) hours_cnt++;
      if (o_minutes_inc_stb) min_cnt++;
      if (o_div_en) div_cnt++;
      if (o_fast_set) fast_cnt++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_hours_inc_stb) hours_cnt++;
      if (o_minutes_inc_stb) min_cnt++;
      if (o_div_en) div_cnt++;
      if (o_fast_set) fast_cnt++;
    end
    tests_run++;
    if (hours_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL tap_hours_count got=%0d exp=1", hours_cnt);
    end
    tests_run++;
    if (div_cnt != 5) begin
      tests_failed++;
      $display("[TB] FAIL tap_div_en_cycles got=%0d exp=5", div_cnt);
    end
    tests_run++;
    if ((fast_cnt != 0) || (min_cnt != 0)) begin
      tests_failed++;
      $display("[TB] FAIL tap_spurious fast=%0d min=%0d exp=0/0", fast_cnt, min_cnt);
    end
    $display("[TB] tap: hours_strobes=%0d div_en_cycles=%0d", hours_cnt, div_cnt);
  endtask

  task automatic test_slow_hold();
    int min_cnt  = 0;
    int fast_cnt = 0;
    int late     = 0;
    i_set_minutes = 1'b1;
    tick();
    if (o_minutes_inc_stb) min_cnt++;
    tests_run++;
    if (o_minutes_inc_stb !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL slow_immediate got=%b exp=1", o_minutes_inc_stb);
    end
    for (int p = 0; p < 2; p++) begin
      tick();
      if (o_minutes_inc_stb) late++;
      if (o_fast_set) fast_cnt++;
      i_timeset_stb = 1'b1;
      tick();
      i_timeset_stb = 1'b0;
      if (o_fast_set) fast_cnt++;
      tests_run++;
      if (o_minutes_inc_stb !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL slow_stb_latency pulse=%0d got=%b exp=1", p, o_minutes_inc_stb);
      end
      if (o_minutes_inc_stb) min_cnt++;
      tick();
      if (o_minutes_inc_stb) late++;
    end
    tests_run++;
    if ((min_cnt != 3) || (late != 0) || (fast_cnt != 0)) begin
      tests_failed++;
      $display("[TB] FAIL slow_count strobes=%0d extra=%0d fast=%0d exp=3/0/0", min_cnt, late, fast_cnt);
    end
    i_set_minutes = 1'b0;
    tick();
    tests_run++;
    if (o_div_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL slow_release_div_en got=%b exp=0", o_div_en);
    end
    $display("[TB] slow_hold: minutes_strobes=%0d", min_cnt);
  endtask

  task automatic test_fast();
    i_set_hours = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      i_1hz_stb = 1'b1;
      // Third tick coincides with a divider strobe: both must take effect
      if (k == 3) i_timeset_stb = 1'b1;
      tick();
      i_1hz_stb     = 1'b0;
      i_timeset_stb = 1'b0;
      tests_run++;
      if (o_fast_set !== (k == 3)) begin
        tests_failed++;
        $display("[TB] FAIL fast_rise k=%0d got=%b exp=%b", k, o_fast_set, (k == 3));
      end
    end
    tests_run++;
    if (o_hours_inc_stb !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fast_coincident_stb got=%b exp=1", o_hours_inc_stb);
    end
    // More 1 Hz ticks: counter saturates, mode stays fast
    for (int k = 0; k < 6; k++) begin
      i_1hz_stb = 1'b1;
      tick();
      i_1hz_stb = 1'b0;
      tick();
    end
    i_timeset_stb = 1'b1;
    tick();
    i_timeset_stb = 1'b0;
    tests_run++;
    if ({o_hours_inc_stb, o_minutes_inc_stb, o_fast_set, o_div_en} !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL fast_mode_strobe got=%b exp=1011",
               {o_hours_inc_stb, o_minutes_inc_stb, o_fast_set, o_div_en});
    end
    i_set_hours = 1'b0;
    tick();
    tests_run++;
    if ({o_fast_set, o_div_en, o_setting} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL fast_release got=%b exp=000", {o_fast_set, o_div_en, o_setting});
    end
    // Hold counter must have been cleared: two ticks are not enough now
    i_set_hours = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      i_1hz_stb = 1'b1;
      tick();
      i_1hz_stb = 1'b0;
      tick();
    end
    tests_run++;
    if (o_fast_set !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fast_hold_cleared got=%b exp=0", o_fast_set);
    end
    i_set_hours = 1'b0;
    tick();
    tick();
    $display("[TB] fast: transition and saturation checked");
  endtask

  task automatic test_simultaneous();
    i_set_hours   = 1'b1;
    i_set_minutes = 1'b1;
    tick();
    tests_run++;
    if ({o_hours_inc_stb, o_minutes_inc_stb, o_setting} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL simul_priority got=%b exp=101", {o_hours_inc_stb, o_minutes_inc_stb, o_setting});
    end
    tick();
    i_set_hours = 1'b0;
    tick();
    tests_run++;
    if ({o_hours_inc_stb, o_minutes_inc_stb, o_setting} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL simul_gap got=%b exp=000", {o_hours_inc_stb, o_minutes_inc_stb, o_setting});
    end
    tick();
    tests_run++;
    if ({o_hours_inc_stb, o_minutes_inc_stb, o_setting} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL simul_minutes_start got=%b exp=011", {o_hours_inc_stb, o_minutes_inc_stb, o_setting});
    end
    i_set_minutes = 1'b0;
    tick();
    tick();
    $display("[TB] simultaneous: hours first, minutes after release");
  endtask

  task automatic test_release_vs_strobe();
    i_set_minutes = 1'b1;
    tick();
    tick();
    i_set_minutes = 1'b0;
    i_timeset_stb = 1'b1;
    tick();
    i_timeset_stb = 1'b0;
    tests_run++;
    if ({o_minutes_inc_stb, o_hours_inc_stb, o_div_en, o_setting} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL release_vs_strobe got=%b exp=0000",
               {o_minutes_inc_stb, o_hours_inc_stb, o_div_en, o_setting});
    end
    tick();
    $display("[TB] release_vs_strobe: strobe suppressed");
  endtask

  task automatic test_reset_mid();
    i_set_minutes = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_1hz_stb = 1'b1;
      tick();
      i_1hz_stb = 1'b0;
    end
    tests_run++;
    if (o_fast_set !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_reach_fast got=%b exp=1", o_fast_set);
    end
    #2;
    i_reset = 1'b1;
    #1;
    tests_run++;
    if ({o_div_en, o_fast_set, o_hours_inc_stb, o_minutes_inc_stb, o_setting} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_async got=%b exp=00000",
               {o_div_en, o_fast_set, o_hours_inc_stb, o_minutes_inc_stb, o_setting});
    end
    tick();
    #2;
    i_reset = 1'b0;
    #1;
    tests_run++;
    if (o_minutes_inc_stb !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_no_early_stb got=%b exp=0", o_minutes_inc_stb);
    end
    tick();
    tests_run++;
    if ({o_minutes_inc_stb, o_div_en, o_fast_set} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_restart got=%b exp=110", {o_minutes_inc_stb, o_div_en, o_fast_set});
    end
    tick();
    tests_run++;
    if (o_minutes_inc_stb !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_single got=%b exp=0", o_minutes_inc_stb);
    end
    i_set_minutes = 1'b0;
    tick();
    $display("[TB] reset_mid: async clear and restart checked");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_tap();
    test_slow_hold();
    test_fast();
    test_simultaneous();
    test_release_vs_strobe();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
